// File: rtl/core_issue_pkg.sv
// rtl/core_issue_pkg.sv - shared types, sizes and helpers for the issue controller
package core_issue_pkg;

  localparam int REG_NUM_W = 5;
  localparam int NUM_REGS  = 32;

  // Clears the x0 bit of a register bitmap; x0 is never tracked.
  localparam logic [NUM_REGS-1:0] NO_X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SHADOW = 2'd2
  } issue_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_NUM_W-1:0] num);
    logic [NUM_REGS-1:0] vec;
    vec      = '0;
    vec[num] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/core_issue_scoreboard.sv
// rtl/core_issue_scoreboard.sv - pending-register bitmap, in-flight counter and writeback bypass
module core_issue_scoreboard
  import core_issue_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_NUM_W-1:0] set_num,
  input  logic                 wb_valid,
  input  logic [REG_NUM_W-1:0] wb_num,
  output logic [NUM_REGS-1:0]  pending,
  output logic [CNT_W-1:0]     out_cnt,
  output logic [NUM_REGS-1:0]  eff_pending,
  output logic [CNT_W-1:0]     eff_cnt,
  output logic                 busy_err
);

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                cnt_dec;
  logic                err_set;

  // Same-cycle writeback bypass: a completing op frees its register and slot immediately.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid) begin
      wb_mask = reg_onehot(wb_num) & NO_X0_MASK;
    end
    if (set_en && (set_num != '0)) begin
      set_mask = reg_onehot(set_num);
    end
    cnt_dec     = wb_valid && (out_cnt != '0);
    eff_pending = pending & ~wb_mask;
    eff_cnt     = out_cnt - CNT_W'(cnt_dec);
    err_set     = wb_valid && ((out_cnt == '0) || ((wb_num != '0) && !pending[wb_num]));
  end

  // Tracking state; a new long op setting a bit wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      out_cnt  <= '0;
      busy_err <= 1'b0;
    end else begin
      pending  <= (eff_pending | set_mask) & NO_X0_MASK;
      out_cnt  <= eff_cnt + CNT_W'(set_en);
      busy_err <= busy_err | err_set;
    end
  end

endmodule

// File: rtl/core_issue_ctrl.sv
// rtl/core_issue_ctrl.sv - in-order issue control with hazard stall, drain and redirect shadow
module core_issue_ctrl
  import core_issue_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3,
  parameter int SHADOW  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DEC_VALID,
  input  logic [REG_NUM_W-1:0] RD_NUM,
  input  logic [REG_NUM_W-1:0] RS1_NUM,
  input  logic [REG_NUM_W-1:0] RS2_NUM,
  input  logic                 DEC_LONG,
  input  logic                 DEC_SERIAL,
  input  logic                 DEC_REDIRECT,
  input  logic                 WB_VALID,
  input  logic [REG_NUM_W-1:0] WB_NUM,
  output logic                 ISSUE,
  output logic                 STALL,
  output logic                 SQUASH,
  output logic [NUM_REGS-1:0]  PENDING,
  output logic [CNT_W-1:0]     OUT_CNT,
  output logic                 BUSY_ERR
);

  localparam int SH_W = (SHADOW > 1) ? $clog2(SHADOW) : 1;

  issue_state_t        state, state_nxt;
  logic [SH_W-1:0]     sh_cnt, sh_cnt_nxt;
  logic [NUM_REGS-1:0] eff_pending;
  logic [CNT_W-1:0]    eff_cnt;
  logic                hazard;
  logic                full;
  logic                drained;

  core_issue_scoreboard #(.CNT_W(CNT_W)) u_scoreboard (
    .clk         (CLK),
    .rst         (RST),
    .set_en      (ISSUE && DEC_LONG),
    .set_num     (RD_NUM),
    .wb_valid    (WB_VALID),
    .wb_num      (WB_NUM),
    .pending     (PENDING),
    .out_cnt     (OUT_CNT),
    .eff_pending (eff_pending),
    .eff_cnt     (eff_cnt),
    .busy_err    (BUSY_ERR)
  );

  // Hazards are judged against the bypassed scoreboard; the RD term catches WAW.
  always_comb begin
    hazard  = ((RS1_NUM != '0) && eff_pending[RS1_NUM]) ||
              ((RS2_NUM != '0) && eff_pending[RS2_NUM]) ||
              ((RD_NUM  != '0) && eff_pending[RD_NUM]);
    full    = (eff_cnt == CNT_W'(MAX_OUT));
    drained = (eff_cnt == '0);
  end

  // Control state register; reset drops all drain and shadow progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_RUN;
      sh_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sh_cnt <= sh_cnt_nxt;
    end
  end

  // Issue decision, next-state selection and decode-facing handshake outputs.
  always_comb begin
    state_nxt  = state;
    sh_cnt_nxt = sh_cnt;
    ISSUE      = 1'b0;
    SQUASH     = 1'b0;
    case (state)
      ST_RUN: begin
        ISSUE = DEC_VALID && !RST && !hazard &&
                !(DEC_LONG && full) && !(DEC_SERIAL && !drained);
        if (DEC_VALID && DEC_SERIAL && !drained && !hazard) begin
          state_nxt = ST_DRAIN;
        end else if (ISSUE && DEC_REDIRECT && (SHADOW > 0)) begin
          state_nxt  = ST_SHADOW;
          sh_cnt_nxt = SH_W'(SHADOW - 1);
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_nxt = ST_RUN;
        end
      end
      ST_SHADOW: begin
        SQUASH = 1'b1;
        if (sh_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          sh_cnt_nxt = sh_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    STALL = DEC_VALID && !ISSUE && (state != ST_SHADOW);
  end

endmodule

// File: doc/core_issue_ctrl.md
Name: core_issue_ctrl

Overview:
In-order issue controller between the decode stage and the execute/memory stages. It holds a register scoreboard for long-latency results (loads, IN), which return later through the writeback port. It stalls decode on RAW or WAW hazards and when the outstanding-op limit is reached. It also drains the pipeline before serializing ops (IRET, MVGTNPC, MVGTO, OUT) and squashes wrong-path slots after a PC redirect.

Parameters:
MAX_OUT, 4, maximum long-latency ops in flight (1..2**CNT_W-1)
CNT_W, 3, width of the outstanding counter
SHADOW, 2, squash cycles after a redirecting op issues (0 = none)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
DEC_VALID  in  1  decoded instruction present; decode holds all DEC_*/number inputs stable while STALL=1
RD_NUM  in  5  destination register; 0 = none or x0
RS1_NUM  in  5  source 1; 0 = none
RS2_NUM  in  5  source 2; 0 = none
DEC_LONG  in  1  result returns later via WB (loads, IN)
DEC_SERIAL  in  1  op requires zero outstanding long ops
DEC_REDIRECT  in  1  op changes PC (branch taken/JAL/JALR/IRET)
WB_VALID  in  1  a long op completes this cycle
WB_NUM  in  5  register written by the completing op
ISSUE  out  1  instruction advances this cycle (combinational)
STALL  out  1  DEC_VALID & !ISSUE & state!=SHADOW (combinational)
SQUASH  out  1  state==SHADOW; front end discards the decode slot
PENDING  out  32  scoreboard bitmap; bit 0 always 0
OUT_CNT  out  CNT_W  long ops in flight
BUSY_ERR  out  1  sticky protocol error

Behaviour:
- Reset (async, RST=1): PENDING=0, OUT_CNT=0, state=RUN, shadow counter=0, BUSY_ERR=0. Combinational outputs then follow: ISSUE=0, SQUASH=0, and STALL=0 unless DEC_VALID.
- Writeback bypass, same cycle:
  - wbmask = WB_VALID ? onehot(WB_NUM) & ~1 : 0.
  - effP = PENDING & ~wbmask.
  - effC = OUT_CNT - (WB_VALID & OUT_CNT!=0).
- hazard = (RS1_NUM!=0 & effP[RS1_NUM]) | (RS2_NUM!=0 & effP[RS2_NUM]) | (RD_NUM!=0 & effP[RD_NUM]). The RD term is the WAW check.
- full = (effC == MAX_OUT).
- ISSUE = DEC_VALID & state==RUN & !hazard & !(DEC_LONG & full) & !(DEC_SERIAL & effC!=0).
- Next PENDING = effP | (ISSUE & DEC_LONG & RD_NUM!=0 ? onehot(RD_NUM) : 0). A same-cycle set wins over a clear of the same bit.
- Next OUT_CNT = effC + (ISSUE & DEC_LONG). A long op with RD_NUM=0 still counts; its WB arrives with WB_NUM=0.
- BUSY_ERR is set on either of:
  - WB_VALID & OUT_CNT==0 (no decrement is applied);
  - WB_VALID & WB_NUM!=0 & !PENDING[WB_NUM].
  - It stays set until reset.
- FSM:
  - RUN: if DEC_VALID & DEC_SERIAL & effC!=0 & !hazard, go to DRAIN. Else if ISSUE & DEC_REDIRECT & SHADOW>0, go to SHADOW and load cnt=SHADOW-1.
  - DRAIN: ISSUE is forced 0. When effC==0, return to RUN; the serial op issues the following cycle.
  - SHADOW: ISSUE=0, STALL=0, SQUASH=1. When cnt==0, go to RUN; else cnt-1.
  - Exactly SHADOW squash cycles follow the redirect issue cycle.
- Latency: issue decision is zero-cycle combinational; scoreboard updates are visible the next cycle, except WB, which is bypassed in the same cycle.
- A redirect op is never long. A serial op that is also long has both effects.
- WB arriving during DRAIN or SHADOW is processed normally.
- RST asserted mid-operation discards all in-flight tracking. Late WBs after reset flag BUSY_ERR; the top level resets the load unit on the same RST.

Decomposition:
- Package core_issue_pkg:
  - state typedef: RUN=2'd0, DRAIN=2'd1, SHADOW=2'd2;
  - REG_NUM_W=5, NUM_REGS=32;
  - onehot-of-register function.
- One sub-module, core_issue_scoreboard: PENDING bitmap, OUT_CNT, bypass logic, BUSY_ERR. It exports effP and effC; the FSM and ISSUE logic stay in the top module.

Test Plan:
- LW x5 issues (DEC_LONG, RD=5), then ADD x6,x5,x1 held 3 cycles, WB x5 in cycle 3 -> STALL=1 for cycles 1-2; ISSUE=1 in cycle 3 via bypass; PENDING returns to 0.
- Five back-to-back loads to x1..x5 with no WB, MAX_OUT=4 -> the first four issue; OUT_CNT=4; the fifth stalls until any WB, then issues in that WB cycle.
- IRET (SERIAL+REDIRECT) with OUT_CNT=2 -> enter DRAIN; after two WBs OUT_CNT=0 and return to RUN; IRET issues the next cycle; SQUASH=1 for exactly 2 cycles, then RUN.
- LW x0 -> issues, PENDING stays 0, OUT_CNT=1; WB_NUM=0 -> OUT_CNT=0 and BUSY_ERR stays 0.
- WB_VALID with OUT_CNT=0 -> BUSY_ERR=1, held until RST; OUT_CNT stays 0.
- Load x7 issued in the same cycle as WB x7 for an earlier load to x7 -> the WAW stall is released by the bypass, the new load issues, and PENDING[7]=1 afterwards. Assert RST mid-stall -> all outputs return to their reset values immediately, without waiting for a clock edge.
